// File: rtl/breakout_pkg.sv
// Shared types and sizing helpers for the breakout match sequencer.
package breakout_pkg;

  // Match flow states; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    ATTRACT = 3'd0,
    LOAD    = 3'd1,
    SERVE   = 3'd2,
    PLAY    = 3'd3,
    LOST    = 3'd4,
    CLEAR   = 3'd5,
    OVER    = 3'd6
  } match_state_t;

  // Width needed to hold a block count from 0 up to rows*cols inclusive.
  function automatic int block_count_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

  // Block counter width for the default 16x13 playfield.
  localparam int BLOCK_COUNT_W = block_count_w(16, 13);

endpackage

// File: rtl/breakout_match_ctrl_if.sv
// Playfield <-> match sequencer signal bundle.
// All event inputs are single-cycle pulses (btn_select is a level); there is
// no backpressure: the sequencer consumes each pulse in the cycle it is seen,
// and every status output is a registered level updated one cycle later.
interface breakout_match_ctrl_if
  import breakout_pkg::*;
#(
  parameter int SCORE_DIGITS = 4,
  parameter int BLK_W        = BLOCK_COUNT_W
);
  logic                      frame_pulse;
  logic                      btn_select;
  logic                      block_hit;
  logic                      ball_lost;
  match_state_t              state;
  logic                      ball_hold;
  logic                      ball_run;
  logic                      reload_blocks;
  logic [3:0]                lives;
  logic [3:0]                level;
  logic [4*SCORE_DIGITS-1:0] score;
  logic [BLK_W-1:0]          blocks_left;
  logic                      game_over;

  // Playfield side: produces events, consumes controls and status.
  modport master (
    output frame_pulse, btn_select, block_hit, ball_lost,
    input  state, ball_hold, ball_run, reload_blocks, lives, level,
           score, blocks_left, game_over
  );

  // Sequencer side.
  modport slave (
    input  frame_pulse, btn_select, block_hit, ball_lost,
    output state, ball_hold, ball_run, reload_blocks, lives, level,
           score, blocks_left, game_over
  );
endinterface

// File: rtl/breakout_match_ctrl_bcd.sv
// Multi-digit BCD counter: synchronous clear, +1 with ripple carry,
// saturating at all nines.
module bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_inc,
  output logic [4*DIGITS-1:0] o_count
);
  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] w_next;
  logic                w_all_nines;

  // Increment value with decimal ripple carry, and saturation detect.
  always_comb begin
    logic carry;
    w_next      = r_count;
    w_all_nines = 1'b1;
    carry       = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_count[4*d +: 4] != 4'd9) w_all_nines = 1'b0;
      if (carry) begin
        if (r_count[4*d +: 4] == 4'd9) begin
          w_next[4*d +: 4] = 4'd0;
        end else begin
          w_next[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  // Count register; clear beats increment, all-nines holds.
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_count <= '0;
    else if (i_inc && !w_all_nines) r_count <= w_next;
  end

  assign o_count = r_count;
endmodule

// File: rtl/breakout_match_ctrl.sv
// Match sequencer: lives, BCD score, level, blocks remaining and the
// attract/serve/play/lost/clear/over flow for one breakout playfield.
module breakout_match_ctrl
  import breakout_pkg::*;
#(
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 13,
  parameter int LIVES        = 3,
  parameter int SCORE_DIGITS = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 90
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  en,
  breakout_match_ctrl_if.slave bus
);
  localparam int BLK_W      = block_count_w(NUM_ROWS, NUM_COLS);
  localparam int MAX_FRAMES = (SERVE_FRAMES > LOST_FRAMES) ? SERVE_FRAMES : LOST_FRAMES;
  localparam int FRAME_W    = $clog2(MAX_FRAMES + 1);
  localparam logic [BLK_W-1:0]   TOTAL_BLOCKS = BLK_W'(NUM_ROWS * NUM_COLS);
  localparam logic [FRAME_W-1:0] SERVE_LAST   = FRAME_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] LOST_LAST    = FRAME_W'(LOST_FRAMES - 1);
  localparam logic [3:0]         LIVES_INIT   = 4'(LIVES);

  match_state_t       r_state, w_next_state;
  logic [3:0]         r_lives, w_next_lives;
  logic [3:0]         r_level, w_next_level;
  logic [BLK_W-1:0]   r_blocks, w_next_blocks;
  logic [FRAME_W-1:0] r_frames, w_next_frames;
  logic               r_btn_q;
  logic               r_hold, r_run, r_reload, r_over;
  logic               w_btn_edge, w_hit_ok, w_score_clr, w_score_inc;

  // Held-through-reset buttons give no edge because r_btn_q resets to 1.
  assign w_btn_edge = bus.btn_select & ~r_btn_q;
  // A hit on an empty field is dropped so the count cannot underflow.
  assign w_hit_ok   = bus.block_hit && (r_blocks != '0);

  // Next-state, counter updates and frame wait bookkeeping.
  always_comb begin
    w_next_state  = r_state;
    w_next_lives  = r_lives;
    w_next_level  = r_level;
    w_next_blocks = r_blocks;
    w_score_clr   = 1'b0;
    w_score_inc   = 1'b0;
    case (r_state)
      ATTRACT: if (w_btn_edge) begin
        w_score_clr  = 1'b1;
        w_next_lives = LIVES_INIT;
        w_next_level = 4'd1;
        w_next_state = LOAD;
      end
      LOAD: begin
        w_next_blocks = TOTAL_BLOCKS;
        w_next_state  = SERVE;
      end
      SERVE: if (w_btn_edge || (bus.frame_pulse && r_frames == SERVE_LAST)) w_next_state = PLAY;
      PLAY: begin
        if (w_hit_ok) begin
          w_next_blocks = r_blocks - BLK_W'(1);
          w_score_inc   = 1'b1;
        end
        // Clearing the field wins over a simultaneous lost ball.
        if (w_hit_ok && r_blocks == BLK_W'(1)) begin
          w_next_state = CLEAR;
        end else if (bus.ball_lost) begin
          w_next_lives = r_lives - 4'd1;
          w_next_state = (r_lives > 4'd1) ? LOST : OVER;
        end
      end
      LOST: if (bus.frame_pulse && r_frames == LOST_LAST) w_next_state = SERVE;
      CLEAR: if (bus.frame_pulse && r_frames == LOST_LAST) begin
        w_next_level = (r_level == 4'd15) ? 4'd1 : r_level + 4'd1;
        w_next_state = LOAD;
      end
      OVER: if (w_btn_edge) w_next_state = ATTRACT;
      default: w_next_state = ATTRACT;
    endcase
    // Every state change restarts the frame wait from zero.
    if (w_next_state != r_state) begin
      w_next_frames = '0;
    end else if (bus.frame_pulse && (r_state == SERVE || r_state == LOST || r_state == CLEAR)) begin
      w_next_frames = r_frames + FRAME_W'(1);
    end else begin
      w_next_frames = r_frames;
    end
  end

  // State and counter registers; outputs are registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ATTRACT;
      r_lives  <= '0;
      r_level  <= '0;
      r_blocks <= '0;
      r_frames <= '0;
      r_btn_q  <= 1'b1;
      r_hold   <= 1'b0;
      r_run    <= 1'b0;
      r_reload <= 1'b0;
      r_over   <= 1'b0;
    end else if (en) begin
      r_state  <= w_next_state;
      r_lives  <= w_next_lives;
      r_level  <= w_next_level;
      r_blocks <= w_next_blocks;
      r_frames <= w_next_frames;
      r_btn_q  <= bus.btn_select;
      r_hold   <= (w_next_state == SERVE);
      r_run    <= (w_next_state == PLAY);
      r_reload <= (w_next_state == LOAD);
      r_over   <= (w_next_state == OVER);
    end
  end

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (en & w_score_clr),
    .i_inc   (en & w_score_inc),
    .o_count (bus.score)
  );

  assign bus.state         = r_state;
  assign bus.lives         = r_lives;
  assign bus.level         = r_level;
  assign bus.blocks_left   = r_blocks;
  assign bus.ball_hold     = r_hold;
  assign bus.ball_run      = r_run;
  assign bus.reload_blocks = r_reload;
  assign bus.game_over     = r_over;
endmodule

// File: tb/tb_breakout_match_ctrl.sv
// Bench for breakout_match_ctrl: two configurations driven by shared
// stimulus, each checked every cycle against a rule-level match model,
// plus literal expectations at the key points of a scripted game.
module tb_breakout_match_ctrl;
  import breakout_pkg::*;

  typedef struct {
    int total; int lives0; int digits; int serve_f; int lost_f;
  } cfg_t;

  typedef struct {
    match_state_t st;
    int lives; int level; int score; int blocks; int frames;
    bit btn_prev;
  } mdl_t;

  // Clock/reset and shared stimulus
  logic clk, rst, en, fp, btn, hit, lost;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_on = 1'b0;
  cfg_t cfg_a, cfg_b;
  mdl_t ma, mb;

  breakout_match_ctrl_if #(.SCORE_DIGITS(4), .BLK_W(8)) ifa ();
  breakout_match_ctrl_if #(.SCORE_DIGITS(2), .BLK_W(2)) ifb ();
  assign ifa.frame_pulse = fp;  assign ifb.frame_pulse = fp;
  assign ifa.btn_select  = btn; assign ifb.btn_select  = btn;
  assign ifa.block_hit   = hit; assign ifb.block_hit   = hit;
  assign ifa.ball_lost   = lost; assign ifb.ball_lost  = lost;

  breakout_match_ctrl #(
    .NUM_ROWS(16), .NUM_COLS(13), .LIVES(3), .SCORE_DIGITS(4),
    .SERVE_FRAMES(60), .LOST_FRAMES(90)
  ) dut_a (.clk(clk), .rst(rst), .en(en), .bus(ifa));

  breakout_match_ctrl #(
    .NUM_ROWS(1), .NUM_COLS(2), .LIVES(3), .SCORE_DIGITS(2),
    .SERVE_FRAMES(4), .LOST_FRAMES(5)
  ) dut_b (.clk(clk), .rst(rst), .en(en), .bus(ifb));

  // Reference model: the match rules stated as plain arithmetic
  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = ATTRACT; m.lives = 0; m.level = 0; m.score = 0;
    m.blocks = 0; m.frames = 0; m.btn_prev = 1'b1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input cfg_t c, input bit r, input bit e,
                                    input bit f, input bit b, input bit h, input bit l);
    bit edge_seen;
    int max_score;
    if (r) return mdl_reset();
    if (!e) return m;
    edge_seen  = b && !m.btn_prev;
    m.btn_prev = b;
    max_score  = 1;
    for (int i = 0; i < c.digits; i++) max_score = max_score * 10;
    max_score = max_score - 1;
    case (m.st)
      ATTRACT: if (edge_seen) begin
        m.score = 0; m.lives = c.lives0; m.level = 1; m.st = LOAD;
      end
      LOAD: begin m.blocks = c.total; m.st = SERVE; m.frames = 0; end
      SERVE: begin
        if (f) m.frames++;
        if (edge_seen || m.frames == c.serve_f) begin m.st = PLAY; m.frames = 0; end
      end
      PLAY: begin
        if (h && m.blocks > 0) begin
          m.blocks--;
          if (m.score < max_score) m.score++;
          if (m.blocks == 0) begin m.st = CLEAR; m.frames = 0; return m; end
        end
        if (l) begin
          m.lives--;
          m.st = (m.lives > 0) ? LOST : OVER;
          m.frames = 0;
        end
      end
      LOST: begin
        if (f) m.frames++;
        if (m.frames == c.lost_f) begin m.st = SERVE; m.frames = 0; end
      end
      CLEAR: begin
        if (f) m.frames++;
        if (m.frames == c.lost_f) begin
          m.level = m.level % 15 + 1; m.st = LOAD; m.frames = 0;
        end
      end
      OVER: if (edge_seen) m.st = ATTRACT;
      default: m.st = ATTRACT;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int digits);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    ma = mdl_step(ma, cfg_a, rst, en, fp, btn, hit, lost);
    mb = mdl_step(mb, cfg_b, rst, en, fp, btn, hit, lost);
  end

  // Scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag, input mdl_t m, input cfg_t c,
                             input logic [2:0] st, input logic hold, input logic run,
                             input logic rel, input logic go, input logic [3:0] lv,
                             input logic [3:0] lvl, input logic [31:0] sc, input logic [31:0] bl);
    chk({tag, ".state"},  32'(st),   32'(m.st));
    chk({tag, ".hold"},   32'(hold), 32'(m.st == SERVE));
    chk({tag, ".run"},    32'(run),  32'(m.st == PLAY));
    chk({tag, ".reload"}, 32'(rel),  32'(m.st == LOAD));
    chk({tag, ".over"},   32'(go),   32'(m.st == OVER));
    chk({tag, ".lives"},  32'(lv),   32'(m.lives));
    chk({tag, ".level"},  32'(lvl),  32'(m.level));
    chk({tag, ".score"},  sc,        to_bcd(m.score, c.digits));
    chk({tag, ".blocks"}, bl,        32'(m.blocks));
  endtask

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check_model("A", ma, cfg_a, ifa.state, ifa.ball_hold, ifa.ball_run, ifa.reload_blocks,
                  ifa.game_over, ifa.lives, ifa.level, 32'(ifa.score), 32'(ifa.blocks_left));
      check_model("B", mb, cfg_b, ifb.state, ifb.ball_hold, ifb.ball_run, ifb.reload_blocks,
                  ifb.game_over, ifb.lives, ifb.level, 32'(ifb.score), 32'(ifb.blocks_left));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn = 1'b1; tick(); btn = 1'b0; tick();
  endtask

  task automatic hit_once();
    hit = 1'b1; tick(); hit = 1'b0; tick();
  endtask

  task automatic frames(input int n);
    repeat (n) begin fp = 1'b1; tick(); fp = 1'b0; tick(); end
  endtask

  task automatic last_frame();
    fp = 1'b1; tick(); fp = 1'b0;
  endtask

  task automatic chk_state_a(input string nm, input match_state_t s);
    chk(nm, 32'(ifa.state), 32'(s));
  endtask

  // Stimulus sequence
  initial begin
    cfg_a = '{total: 208, lives0: 3, digits: 4, serve_f: 60, lost_f: 90};
    cfg_b = '{total: 2,   lives0: 3, digits: 2, serve_f: 4,  lost_f: 5};
    ma = mdl_reset();
    mb = mdl_reset();
    rst = 1'b1; en = 1'b1; fp = 1'b0; btn = 1'b0; hit = 1'b0; lost = 1'b0;
    tick();
    chk_on = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_state_a("reset_state", ATTRACT);
    chk("reset_lives", 32'(ifa.lives), 32'd0);
    chk("reset_score", 32'(ifa.score), 32'd0);

    // Game 1: start, auto-serve, score, lose all lives
    btn = 1'b1; tick();
    chk_state_a("load_state", LOAD);
    chk("load_reload", 32'(ifa.reload_blocks), 32'd1);
    chk("load_lives", 32'(ifa.lives), 32'd3);
    chk("load_level", 32'(ifa.level), 32'd1);
    btn = 1'b0; tick();
    chk_state_a("serve_state", SERVE);
    chk("serve_blocks", 32'(ifa.blocks_left), 32'd208);
    chk("serve_reload_low", 32'(ifa.reload_blocks), 32'd0);
    frames(59);
    chk_state_a("serve_59", SERVE);
    last_frame();
    chk_state_a("serve_60_play", PLAY);
    chk("play_run", 32'(ifa.ball_run), 32'd1);
    repeat (12) hit_once();
    chk("score_12", 32'(ifa.score), 32'h0012);
    chk("blocks_196", 32'(ifa.blocks_left), 32'd196);
    for (int k = 1; k <= 3; k++) begin
      lost = 1'b1; tick(); lost = 1'b0;
      chk("lost_lives", 32'(ifa.lives), 32'(3 - k));
      if (k < 3) begin
        chk_state_a("lost_state", LOST);
        frames(89);
        chk_state_a("lost_89", LOST);
        last_frame();
        chk_state_a("lost_to_serve", SERVE);
        tick();
        press();
        chk_state_a("btn_serve_play", PLAY);
      end else begin
        chk_state_a("over_state", OVER);
        chk("over_flag", 32'(ifa.game_over), 32'd1);
        chk("over_score_held", 32'(ifa.score), 32'h0012);
      end
    end
    press();
    chk_state_a("over_to_attract", ATTRACT);

    // Game 2: small field clear on B; last hit plus lost ball on A
    rst = 1'b1; tick(); rst = 1'b0; tick();
    press();
    press();
    chk_state_a("g2_play", PLAY);
    hit_once(); hit_once();
    chk("b_clear_state", 32'(ifb.state), 32'(CLEAR));
    chk("b_clear_blocks", 32'(ifb.blocks_left), 32'd0);
    chk("b_clear_score", 32'(ifb.score), 32'h02);
    repeat (205) hit_once();
    chk("a_blocks_1", 32'(ifa.blocks_left), 32'd1);
    chk("a_score_207", 32'(ifa.score), 32'h0207);
    hit = 1'b1; lost = 1'b1; tick(); hit = 1'b0; lost = 1'b0;
    chk_state_a("last_hit_lost_clear", CLEAR);
    chk("clear_lives_kept", 32'(ifa.lives), 32'd3);
    chk("clear_score", 32'(ifa.score), 32'h0208);
    frames(89);
    last_frame();
    chk_state_a("clear_to_load", LOAD);
    chk("level_2", 32'(ifa.level), 32'd2);
    chk("reload_again", 32'(ifa.reload_blocks), 32'd1);
    tick();
    chk_state_a("lvl2_serve", SERVE);
    chk("lvl2_lives", 32'(ifa.lives), 32'd3);
    chk("lvl2_blocks", 32'(ifa.blocks_left), 32'd208);
    press();
    hit = 1'b1; lost = 1'b1; tick(); hit = 1'b0; lost = 1'b0;
    chk_state_a("hit_lost_state", LOST);
    chk("hit_lost_lives", 32'(ifa.lives), 32'd2);
    chk("hit_lost_score", 32'(ifa.score), 32'h0209);
    chk("hit_lost_blocks", 32'(ifa.blocks_left), 32'd207);

    // Clock enable low in SERVE freezes everything
    rst = 1'b1; tick(); rst = 1'b0; tick();
    press();
    en = 1'b0;
    repeat (10) begin fp = 1'b1; hit = 1'b1; btn = ~btn; tick(); end
    fp = 1'b0; hit = 1'b0; btn = 1'b0; en = 1'b1;
    tick();
    chk_state_a("en_low_hold", SERVE);
    frames(59);
    chk_state_a("en_serve_59", SERVE);
    last_frame();
    chk_state_a("en_serve_60", PLAY);

    // Reset in PLAY wins over en=0
    en = 1'b0; rst = 1'b1; tick();
    chk_state_a("rst_play_state", ATTRACT);
    chk("rst_play_run", 32'(ifa.ball_run), 32'd0);
    chk("rst_play_lives", 32'(ifa.lives), 32'd0);
    chk("rst_play_level", 32'(ifa.level), 32'd0);
    chk("rst_play_blocks", 32'(ifa.blocks_left), 32'd0);
    rst = 1'b0; en = 1'b1; tick();

    // Drive B to score saturation across many levels
    press();
    repeat (800) begin fp = 1'b1; hit = 1'b1; btn = ~btn; tick(); end
    fp = 1'b0; hit = 1'b0; btn = 1'b0; tick();
    chk("b_score_sat", 32'(ifb.score), 32'h99);

    // Randomized phase, model-checked every cycle
    repeat (3000) begin
      rst  = ($urandom_range(0, 599) == 0);
      en   = ($urandom_range(0, 9) != 0);
      fp   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      hit  = ($urandom_range(0, 2) == 0);
      lost = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b1; fp = 1'b0; hit = 1'b0; lost = 1'b0;
    tick(); tick();

    // Final report
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
